// File: rtl/sim_mem_pkg.sv
// Shared constants and helpers for the multi-channel simulation RAM model.
package sim_mem_pkg;

    localparam int unsigned MAX_NCH     = 8;
    localparam int unsigned MAX_LATENCY = 15;

    // Read data returned for out-of-range addresses (truncated to DATA_W at use).
    localparam logic [63:0] OOR_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/sim_mem_rr_arb.sv
// Round-robin arbiter: picks the first eligible channel at or after the pointer.
module sim_mem_rr_arb
    import sim_mem_pkg::*;
#(
    parameter int unsigned NCH   = 3,
    parameter int unsigned PTR_W = (NCH > 1) ? clog2(NCH) : 1
) (
    input  logic [NCH-1:0]   elig_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NCH-1:0]   grant_c_o,
    output logic             grant_valid_c_o,
    output logic [PTR_W-1:0] ptr_next_c_o
);

    // Ascending search from the pointer with wrap; pointer holds without a grant.
    always_comb begin
        int unsigned idx;
        grant_c_o       = '0;
        grant_valid_c_o = 1'b0;
        ptr_next_c_o    = ptr_i;
        idx             = 0;
        for (int unsigned j = 0; j < NCH; j++) begin
            idx = (32'(ptr_i) + j) % NCH;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (i == idx && elig_i[i] && !grant_valid_c_o) begin
                    grant_c_o[i]    = 1'b1;
                    grant_valid_c_o = 1'b1;
                    ptr_next_c_o    = PTR_W'((i + 1) % NCH);
                end
            end
        end
    end

endmodule

// File: rtl/sim_mem_multiport.sv
// Behavioural RAM shared by NCH requesters with round-robin grant and fixed latency.
module sim_mem_multiport
    import sim_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 22,
    parameter int unsigned DEPTH   = 131072,
    parameter int unsigned NCH     = 3,
    parameter int unsigned LATENCY = 2
) (
    input  logic                    cpu_clk,
    input  logic                    reset,
    input  logic                    inhibit,
    input  logic [NCH-1:0]          ch_req,
    input  logic [NCH-1:0]          ch_write,
    input  logic [NCH*ADDR_W-1:0]   ch_addr,
    input  logic [NCH*DATA_W-1:0]   ch_wdata,
    output logic [NCH*DATA_W-1:0]   ch_rdata,
    output logic [NCH-1:0]          ch_ready,
    output logic [NCH-1:0]          ch_done,
    output logic [NCH-1:0]          ch_busy,
    output logic                    oor_err
);

    localparam int unsigned IDX_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam int unsigned CH_W  = (NCH > 1) ? clog2(NCH) : 1;
    localparam int unsigned LAST  = LATENCY - 1;

    // Storage is zeroed once at time 0 and never touched by reset.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    logic [NCH-1:0]    elig_c, grant_c;
    logic              grant_valid_c;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   sel_idx_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c, rd_c;
    logic              sel_write_c, sel_oor_c;

    logic              vld_q  [LATENCY];
    logic [CH_W-1:0]   chan_q [LATENCY];
    logic              wr_q   [LATENCY];
    logic [DATA_W-1:0] rdat_q [LATENCY];

    logic [NCH*DATA_W-1:0] rdata_d;
    logic [NCH-1:0]        ready_d, done_d, busy_d;
    logic                  oor_d;

    // A channel asserting ch_write alone still counts as a (write) request.
    assign elig_c = (ch_req | ch_write) & ~ch_busy & ~ch_ready & ~ch_done & {NCH{~inhibit}};

    sim_mem_rr_arb #(.NCH(NCH), .PTR_W(CH_W)) u_arb (
        .elig_i          (elig_c),
        .ptr_i           (ptr_q),
        .grant_c_o       (grant_c),
        .grant_valid_c_o (grant_valid_c),
        .ptr_next_c_o    (ptr_d)
    );

    // Mux the granted channel's request fields and classify its address.
    always_comb begin
        sel_idx_c   = '0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        sel_write_c = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_c[i]) begin
                sel_idx_c   = CH_W'(i);
                sel_addr_c  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_c = ch_wdata[i*DATA_W +: DATA_W];
                sel_write_c = ch_write[i];
            end
        end
        sel_oor_c = 64'(sel_addr_c) >= 64'(DEPTH);
        rd_c      = sel_oor_c ? DATA_W'(OOR_FILL) : mem_q[sel_addr_c[IDX_W-1:0]];
    end

    // Commit in-range writes at the grant edge; nothing commits while reset is high.
    always_ff @(posedge cpu_clk) begin
        if (!reset && grant_valid_c && sel_write_c && !sel_oor_c)
            mem_q[sel_addr_c[IDX_W-1:0]] <= sel_wdata_c;
    end

    // Latency pipeline: read data is captured at grant and carried to the response.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < LATENCY; s++) begin
                vld_q[s]  <= 1'b0;
                chan_q[s] <= '0;
                wr_q[s]   <= 1'b0;
                rdat_q[s] <= '0;
            end
        end else begin
            vld_q[0]  <= grant_valid_c;
            chan_q[0] <= sel_idx_c;
            wr_q[0]   <= sel_write_c;
            rdat_q[0] <= rd_c;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                vld_q[s]  <= vld_q[s-1];
                chan_q[s] <= chan_q[s-1];
                wr_q[s]   <= wr_q[s-1];
                rdat_q[s] <= rdat_q[s-1];
            end
        end
    end

    // Response pulses, busy tracking and sticky out-of-range flag.
    always_comb begin
        ready_d = '0;
        done_d  = '0;
        rdata_d = ch_rdata;
        busy_d  = ch_busy | grant_c;
        oor_d   = oor_err | (grant_valid_c & sel_oor_c);
        for (int unsigned i = 0; i < NCH; i++) begin
            if (vld_q[LAST] && chan_q[LAST] == CH_W'(i)) begin
                busy_d[i] = 1'b0;
                if (wr_q[LAST]) begin
                    done_d[i] = 1'b1;
                end else begin
                    ready_d[i]                  = 1'b1;
                    rdata_d[i*DATA_W +: DATA_W] = rdat_q[LAST];
                end
            end
        end
    end

    // Output and pointer registers.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            ptr_q    <= '0;
            ch_ready <= '0;
            ch_done  <= '0;
            ch_busy  <= '0;
            ch_rdata <= '0;
            oor_err  <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            ch_ready <= ready_d;
            ch_done  <= done_d;
            ch_busy  <= busy_d;
            ch_rdata <= rdata_d;
            oor_err  <= oor_d;
        end
    end

endmodule
